// File: rtl/reg_universal.sv
// reg_universal: parametrised universal register with a self-timed serialiser burst.
//
// Operating modes (IDLE, EN=1, start=0): hold, parallel load, shift left/right,
// rotate left/right, synchronous clear. A start request loads D and then shifts the
// word out LSB-first on SO_R over WIDTH enabled cycles, with busy/done status.
//
// Parameters:
//   WIDTH      register width (>= 2)
//   RESET_VAL  value of Q after reset
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   EN     in   clock enable (done still self-clears while low)
//   mode   in   3-bit operation select, used in IDLE only
//   D      in   parallel load data
//   SI_L   in   serial input entering at the MSB on right shifts
//   SI_R   in   serial input entering at the LSB on left shifts
//   start  in   burst request, used in IDLE with EN=1
//   Q      out  register contents
//   SO_L   out  Q[WIDTH-1]
//   SO_R   out  Q[0]
//   busy   out  high while a burst is in progress
//   done   out  one-cycle pulse when a burst completes

module reg_universal #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shr_sil;
  assign shr_sil = {SI_L, q_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;  // done is a pulse: cleared on every edge, even with EN low

    if (EN) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            q_d     = D;
            cnt_d   = '0;
            state_d = StBurst;
            busy_d  = 1'b1;
          end else begin
            unique case (mode)
              3'b000: q_d = q_q;
              3'b001: q_d = D;
              3'b010: q_d = {q_q[WIDTH-2:0], SI_R};
              3'b011: q_d = shr_sil;
              3'b100: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              3'b101: q_d = {q_q[0], q_q[WIDTH-1:1]};
              3'b110: q_d = '0;
              3'b111: q_d = q_q;
              default: q_d = q_q;
            endcase
          end
        end
        StBurst: begin
          q_d = shr_sil;
          // Last bit is on SO_R when the counter reaches WIDTH-1, so it never wraps.
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign SO_L = q_q[WIDTH-1];
  assign SO_R = q_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_reg_universal.sv
// Testbench for reg_universal (WIDTH=8, RESET_VAL=0x3C): table-driven mode vectors,
// hand-written burst/stall/reset sequences and a randomized run against a model.

module tb_reg_universal;

  localparam int unsigned W = 8;
  localparam logic [7:0]  RV = 8'h3C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       EN = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] D = 8'h00;
  logic       SI_L = 1'b0;
  logic       SI_R = 1'b0;
  logic       start = 1'b0;
  logic [7:0] Q;
  logic       SO_L, SO_R, busy, done;

  int nchecks = 0;
  int nerrors = 0;

  reg_universal #(
    .WIDTH    (W),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .EN   (EN),
    .mode (mode),
    .D    (D),
    .SI_L (SI_L),
    .SI_R (SI_R),
    .start(start),
    .Q    (Q),
    .SO_L (SO_L),
    .SO_R (SO_R),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sil;
    logic       sir;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[10];

  // Runs a burst of a given word; EN is dropped for 'stall_len' cycles starting
  // at sample index 'stall_at', and start is re-pulsed at sample 'restart_at'.
  task automatic run_burst(input logic [7:0] word, input int stall_at, input int stall_len,
                           input int restart_at, input string tag);
    logic [7:0] got;
    int         nbits, nbusy, ndone;
    logic       en_now;
    got = 8'h00; nbits = 0; nbusy = 0; ndone = 0;
    EN = 1'b1; mode = 3'b000; SI_L = 1'b0; D = word; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      en_now = !(stall_at >= 0 && k >= stall_at && k < stall_at + stall_len);
      EN = en_now;
      start = (k == restart_at);
      if (busy) begin
        nbusy++;
        if (en_now && nbits < 8) begin
          got[nbits] = SO_R;
          nbits++;
        end else if (!en_now) begin
          check({tag, " stall SO_R"}, 32'(SO_R), 32'(word[stall_at]));
          check({tag, " stall done"}, 32'(done), 32'h0);
        end
      end
      if (done) ndone++;
      tick();
    end
    EN = 1'b1; start = 1'b0;
    check({tag, " bits"}, 32'(got), 32'(word));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(8 + (stall_at >= 0 ? stall_len : 0)));
    check({tag, " done pulses"}, 32'(ndone), 32'h1);
    check({tag, " final Q"}, 32'(Q), 32'h00);
    check({tag, " final busy"}, 32'(busy), 32'h0);
  endtask

  // Reference model state.
  logic [7:0] m_q;
  logic       m_busy, m_done;
  int         m_rem;

  task automatic model_reset();
    m_q = RV; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
  endtask

  task automatic model_step(input logic en, input logic [2:0] md, input logic [7:0] d,
                            input logic sil, input logic sir, input logic st);
    m_done = 1'b0;
    if (en) begin
      if (!m_busy) begin
        if (st) begin
          m_q = d; m_rem = 8; m_busy = 1'b1;
        end else begin
          case (md)
            3'd1: m_q = d;
            3'd2: m_q = (m_q << 1) | 8'(sir);
            3'd3: m_q = (m_q >> 1) | (8'(sil) << 7);
            3'd4: m_q = (m_q << 1) | (m_q >> 7);
            3'd5: m_q = (m_q >> 1) | (m_q << 7);
            3'd6: m_q = 8'h00;
            default: ;
          endcase
        end
      end else begin
        m_q = (m_q >> 1) | (8'(sil) << 7);
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h81};
    vecs[1] = '{1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 8'h03};
    vecs[2] = '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h81};
    vecs[3] = '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h03};
    vecs[4] = '{1'b1, 3'b011, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[5] = '{1'b1, 3'b110, 8'h5A, 1'b1, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 3'b001, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 3'b001, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[8] = '{1'b0, 3'b001, 8'hFF, 1'b1, 1'b1, 8'h00};
    vecs[9] = '{1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 8'hFF};

    // Reset state.
    tick(); tick();
    check("reset Q", 32'(Q), 32'(RV));
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    reset = 1'b0;
    tick();
    check("post-reset hold Q", 32'(Q), 32'(RV));

    // Mode and enable-gating vectors.
    for (int i = 0; i < 10; i++) begin
      EN = vecs[i].en; mode = vecs[i].mode; D = vecs[i].d;
      SI_L = vecs[i].sil; SI_R = vecs[i].sir; start = 1'b0;
      tick();
      check($sformatf("vec%0d Q", i), 32'(Q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d SO_L", i), 32'(SO_L), 32'(vecs[i].exp_q[7]));
      check($sformatf("vec%0d SO_R", i), 32'(SO_R), 32'(vecs[i].exp_q[0]));
    end

    // Asynchronous reset mid-cycle, no clock edge needed.
    #2 reset = 1'b1;
    #1;
    check("async reset Q", 32'(Q), 32'(RV));
    check("async reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // Plain burst with an ignored mid-burst start, then a stalled burst.
    run_burst(8'hA5, -1, 0, 4, "burst");
    run_burst(8'hA5, 2, 2, 6, "stall");

    // Reset mid-burst after the 4th bit.
    EN = 1'b1; D = 8'hA5; SI_L = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre-reset busy", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("midburst reset busy", 32'(busy), 32'h0);
    check("midburst reset Q", 32'(Q), 32'(RV));
    check("midburst reset done", 32'(done), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("no done after reset", 32'(done), 32'h0);
    end
    run_burst(8'h3B, -1, 0, -1, "after reset");

    // Randomized run against the reference model.
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic       en_r, sil_r, sir_r, st_r;
      logic [2:0] md_r;
      logic [7:0] d_r;
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        check("rand reset Q", 32'(Q), 32'(m_q));
      end
      en_r  = ($urandom_range(0, 3) != 0);
      md_r  = 3'($urandom_range(0, 7));
      d_r   = 8'($urandom);
      sil_r = 1'($urandom);
      sir_r = 1'($urandom);
      st_r  = ($urandom_range(0, 9) == 0);
      EN = en_r; mode = md_r; D = d_r; SI_L = sil_r; SI_R = sir_r; start = st_r;
      model_step(en_r, md_r, d_r, sil_r, sir_r, st_r);
      tick();
      check("rand Q", 32'(Q), 32'(m_q));
      check("rand busy", 32'(busy), 32'(m_busy));
      check("rand done", 32'(done), 32'(m_done));
      check("rand SO_L", 32'(SO_L), 32'(m_q[7]));
      check("rand SO_R", 32'(SO_R), 32'(m_q[0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
